// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// funct codes, ALU operations and datapath mux selects.
package multicycle_controller_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALU_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_e;

    typedef enum logic [1:0] {
        SRCB_RD2     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alusrcb_e;

    // Per-state control word driven toward the datapath
    typedef struct packed {
        logic             mem_req;
        logic             iord;
        logic             mem_write;
        logic             ir_write;
        logic             pc_write;
        logic             branch;
        pcsrc_e           pc_src;
        logic             alu_src_a;
        alusrcb_e         alu_src_b;
        logic [ALU_W-1:0] alu_control;
        logic             reg_dest;
        logic             memto_reg;
        logic             reg_write;
        logic             illegal_op;
    } ctrl_t;

    // States whose exit to FETCH completes an instruction
    function automatic logic retires_from(input state_e s);
        case (s)
            S_MEMWR, S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// R-type funct decode to ALU operation; unsupported funct flags illegal and
// falls back to add so the ALU select is always defined.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output logic [ALU_W-1:0]   alu_control_c,
    output logic               illegal_c
);

    // funct -> ALU operation
    always_comb begin
        alu_control_c = ALU_ADD;
        illegal_c     = 1'b0;
        case (funct)
            FN_ADD:  alu_control_c = ALU_ADD;
            FN_SUB:  alu_control_c = ALU_SUB;
            FN_AND:  alu_control_c = ALU_AND;
            FN_OR:   alu_control_c = ALU_OR;
            FN_SLT:  alu_control_c = ALU_SLT;
            default: illegal_c     = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute
// over a shared memory port, stalls on mem_ready and counts retired instructions.
// Outputs decode directly from the state register so FETCH can strobe IRWrite
// and PCEn in the very cycle memory answers.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter bit          USE_READY = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCEn,
    output logic [1:0]         PCSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALU_W-1:0]   ALUControl,
    output logic               RegDest,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired,
    output logic [STATE_W-1:0] state_dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    ctrl_t            ctl_c;
    logic             ready_c;
    logic [ALU_W-1:0] rtype_alu_c;
    logic             rtype_illegal_c;

    assign ready_c = USE_READY ? mem_ready : 1'b1;

    multicycle_controller_alu_decoder u_alu_decoder (
        .funct         (funct),
        .alu_control_c (rtype_alu_c),
        .illegal_c     (rtype_illegal_c)
    );

    // Next-state and per-state control word
    always_comb begin
        state_d = state_q;
        ctl_c   = '0;
        case (state_q)
            S_FETCH: begin
                ctl_c.mem_req     = 1'b1;
                ctl_c.alu_src_b   = SRCB_FOUR;
                ctl_c.alu_control = ALU_ADD;
                ctl_c.pc_src      = PCSRC_ALU;
                if (ready_c) begin
                    ctl_c.ir_write = 1'b1;
                    ctl_c.pc_write = 1'b1;
                    state_d        = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl_c.alu_src_b   = SRCB_IMM_SH2;
                ctl_c.alu_control = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        ctl_c.illegal_op = 1'b1;
                        state_d          = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl_c.alu_src_a   = 1'b1;
                ctl_c.alu_src_b   = SRCB_IMM;
                ctl_c.alu_control = ALU_ADD;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                ctl_c.mem_req = 1'b1;
                ctl_c.iord    = 1'b1;
                if (ready_c) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR: begin
                ctl_c.mem_req   = 1'b1;
                ctl_c.iord      = 1'b1;
                ctl_c.mem_write = 1'b1;
                if (ready_c) begin
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                ctl_c.memto_reg = 1'b1;
                ctl_c.reg_write = 1'b1;
                state_d         = S_FETCH;
            end
            S_EXEC: begin
                ctl_c.alu_src_a   = 1'b1;
                ctl_c.alu_src_b   = SRCB_RD2;
                ctl_c.alu_control = rtype_alu_c;
                if (rtype_illegal_c) begin
                    ctl_c.illegal_op = 1'b1;
                    state_d          = S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                ctl_c.reg_dest  = 1'b1;
                ctl_c.reg_write = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctl_c.alu_src_a   = 1'b1;
                ctl_c.alu_src_b   = SRCB_RD2;
                ctl_c.alu_control = ALU_SUB;
                ctl_c.pc_src      = PCSRC_ALUOUT;
                ctl_c.branch      = 1'b1;
                state_d           = S_FETCH;
            end
            S_ADDIEX: begin
                ctl_c.alu_src_a   = 1'b1;
                ctl_c.alu_src_b   = SRCB_IMM;
                ctl_c.alu_control = ALU_ADD;
                state_d           = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl_c.reg_write = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctl_c.pc_src   = PCSRC_JUMP;
                ctl_c.pc_write = 1'b1;
                state_d        = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Retire count advances when a completing state hands back to FETCH
    always_comb begin
        retired_d = retired_q;
        if ((state_d == S_FETCH) && retires_from(state_q)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Drive ports; side-effecting strobes are held off while reset is high
    assign mem_req    = ctl_c.mem_req;
    assign IorD       = ctl_c.iord;
    assign MemWrite   = ctl_c.mem_write & ~reset;
    assign IRWrite    = ctl_c.ir_write & ~reset;
    assign PCEn       = (ctl_c.pc_write | (ctl_c.branch & zero)) & ~reset;
    assign PCSrc      = ctl_c.pc_src;
    assign ALUSrcA    = ctl_c.alu_src_a;
    assign ALUSrcB    = ctl_c.alu_src_b;
    assign ALUControl = ctl_c.alu_control;
    assign RegDest    = ctl_c.reg_dest;
    assign MemtoReg   = ctl_c.memto_reg;
    assign RegWrite   = ctl_c.reg_write & ~reset;
    assign illegal_op = ctl_c.illegal_op & ~reset;
    assign retired    = retired_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table for the
// instruction mix, hand sequences for reset-in-MEMWR and counter wrap.
module tb_multicycle_controller;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010;

    // {mem_req,IorD,MemWrite,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALUControl,RegDest,MemtoReg,RegWrite,illegal_op}
    localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_1_00_0_01_010_0_0_0_0;
    localparam logic [16:0] C_FSTALL = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
    localparam logic [16:0] C_DECILL = 17'b0_0_0_0_0_00_0_11_010_0_0_0_1;
    localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [16:0] C_MEMRD  = 17'b1_1_0_0_0_00_0_00_000_0_0_0_0;
    localparam logic [16:0] C_MEMWR  = 17'b1_1_1_0_0_00_0_00_000_0_0_0_0;
    localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_00_0_00_000_0_1_1_0;
    localparam logic [16:0] C_EXADD  = 17'b0_0_0_0_0_00_1_00_010_0_0_0_0;
    localparam logic [16:0] C_EXSUB  = 17'b0_0_0_0_0_00_1_00_110_0_0_0_0;
    localparam logic [16:0] C_EXAND  = 17'b0_0_0_0_0_00_1_00_000_0_0_0_0;
    localparam logic [16:0] C_EXOR   = 17'b0_0_0_0_0_00_1_00_001_0_0_0_0;
    localparam logic [16:0] C_EXSLT  = 17'b0_0_0_0_0_00_1_00_111_0_0_0_0;
    localparam logic [16:0] C_EXILL  = 17'b0_0_0_0_0_00_1_00_010_0_0_0_1;
    localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
    localparam logic [16:0] C_BRT    = 17'b0_0_0_0_1_01_1_00_110_0_0_0_0;
    localparam logic [16:0] C_BRN    = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
    localparam logic [16:0] C_ADDIEX = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [16:0] C_ADDIWB = 17'b0_0_0_0_0_00_0_00_000_0_0_1_0;
    localparam logic [16:0] C_JUMP   = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT
    logic        reset, zero, mem_ready;
    logic [5:0]  opcode, funct;
    logic        mem_req, IorD, MemWrite, IRWrite, PCEn, ALUSrcA;
    logic        RegDest, MemtoReg, RegWrite, illegal_op;
    logic [1:0]  PCSrc, ALUSrcB;
    logic [2:0]  ALUControl;
    logic [31:0] retired;
    logic [3:0]  state_dbg;
    logic [16:0] obs;

    assign obs = {mem_req, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                  ALUControl, RegDest, MemtoReg, RegWrite, illegal_op};

    multicycle_controller #(.CNT_W(32), .USE_READY(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDest(RegDest),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal_op(illegal_op),
        .retired(retired), .state_dbg(state_dbg)
    );

    // narrow-counter DUT that ignores mem_ready, fed a stream of jumps
    logic        reset2;
    logic        mem_req2, IorD2, MemWrite2, IRWrite2, PCEn2, ALUSrcA2;
    logic        RegDest2, MemtoReg2, RegWrite2, illegal_op2;
    logic [1:0]  PCSrc2, ALUSrcB2;
    logic [2:0]  ALUControl2;
    logic [3:0]  retired2;
    logic [3:0]  state_dbg2;

    multicycle_controller #(.CNT_W(4), .USE_READY(1'b0)) dut2 (
        .clk(clk), .reset(reset2), .opcode(JMP), .funct(6'b000000), .zero(1'b0),
        .mem_ready(1'b0), .mem_req(mem_req2), .IorD(IorD2), .MemWrite(MemWrite2),
        .IRWrite(IRWrite2), .PCEn(PCEn2), .PCSrc(PCSrc2), .ALUSrcA(ALUSrcA2),
        .ALUSrcB(ALUSrcB2), .ALUControl(ALUControl2), .RegDest(RegDest2),
        .MemtoReg(MemtoReg2), .RegWrite(RegWrite2), .illegal_op(illegal_op2),
        .retired(retired2), .state_dbg(state_dbg2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic rdy, input logic [3:0] st, input logic [16:0] ctl,
                           input logic [31:0] ret);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl; v.ret = ret;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // R-type add: 0,1,6,7
        add_vec(RT, 6'b100000, 0, 1, 4'd0, C_FETCH, 0);
        add_vec(RT, 6'b100000, 0, 1, 4'd1, C_DEC,   0);
        add_vec(RT, 6'b100000, 0, 1, 4'd6, C_EXADD, 0);
        add_vec(RT, 6'b100000, 0, 1, 4'd7, C_ALUWB, 0);
        // lw with two stall cycles in MEMRD (7 cycles)
        add_vec(LW, 6'b000000, 0, 1, 4'd0, C_FETCH,  1);
        add_vec(LW, 6'b000000, 0, 1, 4'd1, C_DEC,    1);
        add_vec(LW, 6'b000000, 0, 1, 4'd2, C_MEMADR, 1);
        add_vec(LW, 6'b000000, 0, 0, 4'd3, C_MEMRD,  1);
        add_vec(LW, 6'b000000, 0, 0, 4'd3, C_MEMRD,  1);
        add_vec(LW, 6'b000000, 0, 1, 4'd3, C_MEMRD,  1);
        add_vec(LW, 6'b000000, 0, 1, 4'd4, C_MEMWB,  1);
        // sw with one FETCH stall and one MEMWR stall
        add_vec(SW, 6'b000000, 0, 0, 4'd0, C_FSTALL, 2);
        add_vec(SW, 6'b000000, 0, 1, 4'd0, C_FETCH,  2);
        add_vec(SW, 6'b000000, 0, 1, 4'd1, C_DEC,    2);
        add_vec(SW, 6'b000000, 0, 1, 4'd2, C_MEMADR, 2);
        add_vec(SW, 6'b000000, 0, 0, 4'd5, C_MEMWR,  2);
        add_vec(SW, 6'b000000, 0, 1, 4'd5, C_MEMWR,  2);
        // beq taken / not taken
        add_vec(BEQ, 6'b000000, 1, 1, 4'd0, C_FETCH, 3);
        add_vec(BEQ, 6'b000000, 1, 1, 4'd1, C_DEC,   3);
        add_vec(BEQ, 6'b000000, 1, 1, 4'd8, C_BRT,   3);
        add_vec(BEQ, 6'b000000, 0, 1, 4'd0, C_FETCH, 4);
        add_vec(BEQ, 6'b000000, 0, 1, 4'd1, C_DEC,   4);
        add_vec(BEQ, 6'b000000, 0, 1, 4'd8, C_BRN,   4);
        // addi
        add_vec(ADI, 6'b000000, 0, 1, 4'd0,  C_FETCH,  5);
        add_vec(ADI, 6'b000000, 0, 1, 4'd1,  C_DEC,    5);
        add_vec(ADI, 6'b000000, 0, 1, 4'd9,  C_ADDIEX, 5);
        add_vec(ADI, 6'b000000, 0, 1, 4'd10, C_ADDIWB, 5);
        // j
        add_vec(JMP, 6'b000000, 0, 1, 4'd0,  C_FETCH, 6);
        add_vec(JMP, 6'b000000, 0, 1, 4'd1,  C_DEC,   6);
        add_vec(JMP, 6'b000000, 0, 1, 4'd11, C_JUMP,  6);
        // illegal opcode: no retire
        add_vec(6'b111111, 6'b000000, 0, 1, 4'd0, C_FETCH,  7);
        add_vec(6'b111111, 6'b000000, 0, 1, 4'd1, C_DECILL, 7);
        // sub / and / or / slt
        add_vec(RT, 6'b100010, 0, 1, 4'd0, C_FETCH, 7);
        add_vec(RT, 6'b100010, 0, 1, 4'd1, C_DEC,   7);
        add_vec(RT, 6'b100010, 0, 1, 4'd6, C_EXSUB, 7);
        add_vec(RT, 6'b100010, 0, 1, 4'd7, C_ALUWB, 7);
        add_vec(RT, 6'b100100, 0, 1, 4'd0, C_FETCH, 8);
        add_vec(RT, 6'b100100, 0, 1, 4'd1, C_DEC,   8);
        add_vec(RT, 6'b100100, 0, 1, 4'd6, C_EXAND, 8);
        add_vec(RT, 6'b100100, 0, 1, 4'd7, C_ALUWB, 8);
        add_vec(RT, 6'b100101, 0, 1, 4'd0, C_FETCH, 9);
        add_vec(RT, 6'b100101, 0, 1, 4'd1, C_DEC,   9);
        add_vec(RT, 6'b100101, 0, 1, 4'd6, C_EXOR,  9);
        add_vec(RT, 6'b100101, 0, 1, 4'd7, C_ALUWB, 9);
        add_vec(RT, 6'b101010, 0, 1, 4'd0, C_FETCH, 10);
        add_vec(RT, 6'b101010, 0, 1, 4'd1, C_DEC,   10);
        add_vec(RT, 6'b101010, 0, 1, 4'd6, C_EXSLT, 10);
        add_vec(RT, 6'b101010, 0, 1, 4'd7, C_ALUWB, 10);
        // illegal funct: back to FETCH, no retire
        add_vec(RT, 6'b000111, 0, 1, 4'd0, C_FETCH,  11);
        add_vec(RT, 6'b000111, 0, 1, 4'd1, C_DEC,    11);
        add_vec(RT, 6'b000111, 0, 1, 4'd6, C_EXILL,  11);
        add_vec(RT, 6'b000000, 0, 0, 4'd0, C_FSTALL, 11);

        reset = 1'b1; reset2 = 1'b1;
        opcode = RT; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;

        // reset state: strobes held off even with memory ready in FETCH
        @(negedge clk);
        #1;
        check("rst_state",   32'(state_dbg), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_pcen",    32'(PCEn), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            #1;
            check($sformatf("v%0d_state", i), 32'(state_dbg), 32'(tbl[i].st));
            check($sformatf("v%0d_ctl", i),   32'(obs),       32'(tbl[i].ctl));
            check($sformatf("v%0d_ret", i),   retired,        tbl[i].ret);
            @(negedge clk);
        end

        // sw, then reset while MemWrite is high
        opcode = SW; funct = 6'b000000; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("memwr_state", 32'(state_dbg), 32'd5);
        check("memwr_wr",    32'(MemWrite), 32'd1);
        mem_ready = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("async_memwrite", 32'(MemWrite), 32'd0);
        check("async_state",    32'(state_dbg), 32'd0);
        check("async_retired",  retired, 32'd0);
        check("async_irwrite",  32'(IRWrite), 32'd0);
        check("async_pcen",     32'(PCEn), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_irwrite", 32'(IRWrite), 32'd1);
        check("post_rst_state",   32'(state_dbg), 32'd0);

        // 4-bit counter, mem_ready ignored: jumps take 3 cycles each
        @(negedge clk);
        reset2 = 1'b0;
        for (int k = 0; k <= 50; k++) begin
            logic [3:0] st_exp;
            #1;
            st_exp = (k % 3 == 0) ? 4'd0 : ((k % 3 == 1) ? 4'd1 : 4'd11);
            check($sformatf("wrap%0d_state", k), 32'(state_dbg2), 32'(st_exp));
            check($sformatf("wrap%0d_ret", k),   32'(retired2),   32'((k / 3) % 16));
            if (k % 3 == 0) begin
                check($sformatf("wrap%0d_irw", k), 32'(IRWrite2), 32'd1);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
